// File: rtl/maxp_ctrl_pkg.sv
// Shared constants and the latched-geometry record for the max-pool read sequencer.
package maxp_ctrl_pkg;
   localparam int MEM_SIZE     = 16;
   localparam int DATA_SIZE    = 16;
   localparam int MAXP_CFG_W   = 12;
   localparam int MAXP_K_W     = 3;
   localparam int DRAIN_CYCLES = 3;

   typedef struct packed {
      logic [MAXP_CFG_W-1:0] in_w;
      logic [MAXP_CFG_W-1:0] in_h;
      logic [MAXP_CFG_W-1:0] out_w;
      logic [MAXP_CFG_W-1:0] out_h;
      logic [MAXP_CFG_W-1:0] ch;
      logic [MAXP_K_W-1:0]   k;
   } maxp_geom_t;
endpackage

// File: rtl/maxp_addr_gen.sv
// Window-walk counters and incremental address adders (kx innermost, channel outermost).
// setup preloads bases and strides; each step advances one read.
module maxp_addr_gen
   import maxp_ctrl_pkg::*;
#(
   parameter int MEM_SIZE = maxp_ctrl_pkg::MEM_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                setup,
   input  logic                step,
   input  maxp_geom_t          geom,
   input  logic [MEM_SIZE-1:0] src_base,
   input  logic [MEM_SIZE-1:0] dst_base,
   output logic [MEM_SIZE-1:0] ra,
   output logic [MEM_SIZE-1:0] wa,
   output logic                win_last,
   output logic                all_last
);
   localparam logic [MEM_SIZE-1:0] A_ONE = MEM_SIZE'(1);

   logic [MAXP_K_W-1:0]   kx_q, kx_d, ky_q, ky_d;
   logic [MAXP_CFG_W-1:0] ox_q, ox_d, oy_q, oy_d, c_q, c_d;
   logic [MEM_SIZE-1:0]   ra_q, ra_d, line_q, line_d, win_q, win_d;
   logic [MEM_SIZE-1:0]   row_q, row_d, plane_q, plane_d, wa_q, wa_d;
   logic [MEM_SIZE-1:0]   plane_stride_q, plane_stride_d, row_step_q, row_step_d;
   logic [MEM_SIZE-1:0]   in_w_m, k_m;
   logic                  kx_end, ky_end, ox_end, oy_end, c_end;

   assign in_w_m = MEM_SIZE'(geom.in_w);
   assign k_m    = MEM_SIZE'(geom.k);

   assign kx_end = (kx_q == geom.k - MAXP_K_W'(1));
   assign ky_end = (ky_q == geom.k - MAXP_K_W'(1));
   assign ox_end = (ox_q == geom.out_w - MAXP_CFG_W'(1));
   assign oy_end = (oy_q == geom.out_h - MAXP_CFG_W'(1));
   assign c_end  = (c_q  == geom.ch - MAXP_CFG_W'(1));

   assign win_last = kx_end & ky_end;
   assign all_last = win_last & ox_end & oy_end & c_end;
   assign ra       = ra_q;
   assign wa       = wa_q;

   always_comb begin
      kx_d = kx_q; ky_d = ky_q; ox_d = ox_q; oy_d = oy_q; c_d = c_q;
      ra_d = ra_q; line_d = line_q; win_d = win_q; row_d = row_q; plane_d = plane_q;
      wa_d = wa_q;
      plane_stride_d = plane_stride_q;
      row_step_d     = row_step_q;
      if (setup) begin
         // The only multiplies: computed once, truncated to the address width.
         plane_stride_d = MEM_SIZE'(geom.in_w) * MEM_SIZE'(geom.in_h);
         row_step_d     = k_m * in_w_m;
         kx_d = '0; ky_d = '0; ox_d = '0; oy_d = '0; c_d = '0;
         ra_d = src_base; line_d = src_base; win_d = src_base;
         row_d = src_base; plane_d = src_base;
         wa_d = dst_base;
      end else if (step) begin
         if (!kx_end) begin
            kx_d = kx_q + MAXP_K_W'(1);
            ra_d = ra_q + A_ONE;
         end else begin
            kx_d = '0;
            if (!ky_end) begin
               ky_d   = ky_q + MAXP_K_W'(1);
               line_d = line_q + in_w_m;
               ra_d   = line_d;
            end else begin
               ky_d = '0;
               wa_d = wa_q + A_ONE;
               if (!ox_end) begin
                  ox_d   = ox_q + MAXP_CFG_W'(1);
                  win_d  = win_q + k_m;
                  line_d = win_d;
                  ra_d   = win_d;
               end else begin
                  ox_d = '0;
                  if (!oy_end) begin
                     oy_d   = oy_q + MAXP_CFG_W'(1);
                     row_d  = row_q + row_step_q;
                     win_d  = row_d;
                     line_d = row_d;
                     ra_d   = row_d;
                  end else begin
                     oy_d    = '0;
                     c_d     = c_q + MAXP_CFG_W'(1);
                     plane_d = plane_q + plane_stride_q;
                     row_d   = plane_d;
                     win_d   = plane_d;
                     line_d  = plane_d;
                     ra_d    = plane_d;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kx_q <= '0; ky_q <= '0; ox_q <= '0; oy_q <= '0; c_q <= '0;
         ra_q <= '0; line_q <= '0; win_q <= '0; row_q <= '0; plane_q <= '0;
         wa_q <= '0; plane_stride_q <= '0; row_step_q <= '0;
      end else begin
         kx_q <= kx_d; ky_q <= ky_d; ox_q <= ox_d; oy_q <= oy_d; c_q <= c_d;
         ra_q <= ra_d; line_q <= line_d; win_q <= win_d; row_q <= row_d; plane_q <= plane_d;
         wa_q <= wa_d; plane_stride_q <= plane_stride_d; row_step_q <= row_step_d;
      end
   end
endmodule

// File: rtl/maxp_ctrl.sv
// Max-pool controller: FSM, read-to-maxp_unit alignment stage and optional perf counter.
// Define MAXP_CTRL_PERF_EN to add the perf_cycles output.
module maxp_ctrl
   import maxp_ctrl_pkg::*;
#(
   parameter int MEM_SIZE  = maxp_ctrl_pkg::MEM_SIZE,
   parameter int DATA_SIZE = maxp_ctrl_pkg::DATA_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [MEM_SIZE-1:0]   cfg_src_base,
   input  logic [MEM_SIZE-1:0]   cfg_dst_base,
   input  logic [MAXP_CFG_W-1:0] cfg_in_w,
   input  logic [MAXP_CFG_W-1:0] cfg_in_h,
   input  logic [MAXP_CFG_W-1:0] cfg_out_w,
   input  logic [MAXP_CFG_W-1:0] cfg_out_h,
   input  logic [MAXP_K_W-1:0]   cfg_k,
   input  logic [MAXP_CFG_W-1:0] cfg_ch,
   output logic                  mem_re,
   output logic [MEM_SIZE-1:0]   mem_ra,
   output logic                  mp_en,
   output logic                  mp_we,
   output logic [MEM_SIZE-1:0]   mp_wa,
`ifdef MAXP_CTRL_PERF_EN
   output logic [31:0]           perf_cycles,
`endif
   output logic                  busy,
   output logic                  done
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   if (MEM_SIZE < 1 || DATA_SIZE < 1) begin : g_param_chk
      $error("maxp_ctrl: MEM_SIZE and DATA_SIZE must be positive");
   end

   logic [1:0]          state_q, state_d;
   maxp_geom_t          geom_q, geom_d;
   logic [MEM_SIZE-1:0] src_q, src_d, dst_q, dst_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;
   logic                done_q, done_d;
   logic                en_q, en_d, we_q, we_d;
   logic [MEM_SIZE-1:0] wa_q, wa_d;
   logic                run, setup, cfg_zero;
   logic [MEM_SIZE-1:0] ag_ra, ag_wa;
   logic                ag_win_last, ag_all_last;

   assign run      = (state_q == ST_RUN);
   assign setup    = (state_q == ST_SETUP);
   assign cfg_zero = (geom_q.out_w == '0) || (geom_q.out_h == '0) ||
                     (geom_q.k == '0) || (geom_q.ch == '0);

   maxp_addr_gen #(.MEM_SIZE(MEM_SIZE)) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .setup    (setup),
      .step     (run),
      .geom     (geom_q),
      .src_base (src_q),
      .dst_base (dst_q),
      .ra       (ag_ra),
      .wa       (ag_wa),
      .win_last (ag_win_last),
      .all_last (ag_all_last)
   );

   always_comb begin
      state_d = state_q;
      geom_d  = geom_q;
      src_d   = src_q;
      dst_d   = dst_q;
      drain_d = drain_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_SETUP;
            geom_d  = '{in_w: cfg_in_w, in_h: cfg_in_h, out_w: cfg_out_w,
                        out_h: cfg_out_h, ch: cfg_ch, k: cfg_k};
            src_d   = cfg_src_base;
            dst_d   = cfg_dst_base;
         end
         ST_SETUP: if (cfg_zero) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = ST_RUN;
         end
         ST_RUN: if (ag_all_last) begin
            state_d = ST_DRAIN;
            drain_d = '0;
         end
         default: begin
            // Drain covers the maxp_unit result latency for the final window.
            if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + DRAIN_W'(1);
            end
         end
      endcase
   end

   // Read data lands one cycle after mem_re, so maxp_unit controls lag by one.
   always_comb begin
      en_d = run;
      we_d = run & ag_win_last;
      wa_d = run ? ag_wa : wa_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         geom_q  <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         drain_q <= '0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         wa_q    <= '0;
      end else begin
         state_q <= state_d;
         geom_q  <= geom_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         drain_q <= drain_d;
         done_q  <= done_d;
         en_q    <= en_d;
         we_q    <= we_d;
         wa_q    <= wa_d;
      end
   end

   assign mem_re = run;
   assign mem_ra = ag_ra;
   assign mp_en  = en_q;
   assign mp_we  = we_q;
   assign mp_wa  = wa_q;
   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;

`ifdef MAXP_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == ST_IDLE && start) perf_d = '0;
      else if (busy && perf_q != '1)   perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) perf_q <= '0;
      else     perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`endif
endmodule

// File: doc/maxp_ctrl.md
MAXP_CTRL -- requirements
Module: maxp_ctrl

Interface
REQ-001 SHALL use parameters MEM_SIZE (address width) and DATA_SIZE (data width), default values from param.v.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle launch pulse; honoured only in IDLE.
REQ-005 cfg_src_base, cfg_dst_base  in  MEM_SIZE  input plane 0 start address; output start address.
REQ-006 cfg_in_w, cfg_in_h  in  12  input plane width and height in words.
REQ-007 cfg_out_w, cfg_out_h  in  12  output plane width and height, computed by software as floor(in/k).
REQ-008 cfg_k  in  3  square window size and stride, 1..7.
REQ-009 cfg_ch  in  12  channel count; input planes contiguous in memory.
REQ-010 mem_re, mem_ra  out  1, MEM_SIZE  feature-memory read strobe and address; read data returns 1 cycle later, directly into maxp_unit in_data.
REQ-011 mp_en, mp_we, mp_wa  out  1, 1, MEM_SIZE  maxp_unit en, we_in and wa_in, aligned with the returning read data.
REQ-012 busy  out  1  high from the cycle after an accepted start until done.
REQ-013 done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, SETUP, RUN, DRAIN.
REQ-015 Transitions:
- IDLE->SETUP on start; all cfg_* latched on that edge.
- SETUP lasts 1 cycle and registers plane_stride = in_w*in_h and row_step = k*in_w.
- SETUP->RUN, then RUN->DRAIN after the last read is issued.
- DRAIN lasts 3 cycles, then done pulses and the FSM enters IDLE.
REQ-016 If any of cfg_out_w, cfg_out_h, cfg_k or cfg_ch is 0, SETUP SHALL go to IDLE with a done pulse, with no mem_re and no mp_we issued.
REQ-017 In RUN, mem_re=1 every cycle; loop order is channel, oy, ox, ky, kx, with kx innermost.
REQ-018 mem_ra = src_base + c*plane_stride + (oy*k+ky)*in_w + ox*k + kx.
REQ-019 Address calculation SHALL be incremental adders only:
- kx step: +1.
- ky step: line base + in_w.
- ox step: window base + k.
- oy step: row base + row_step.
- c step: plane base + plane_stride.
- Address sums wrap modulo 2^MEM_SIZE.
REQ-020 mp_en SHALL be high exactly during the cycles one cycle after each RUN cycle, i.e. k*k*out_w*out_h*ch consecutive cycles.
REQ-021 mp_we=1 on the cycle carrying the last element of each window (kx=ky=k-1), delayed 1 cycle like mp_en; otherwise 0.
REQ-022 mp_wa = dst_base + window index (0,1,2,... across all channels), valid whenever mp_en=1; held otherwise.
REQ-023 Result write for the final window SHALL appear at the maxp_unit output 2 cycles after its mp_we; done SHALL follow no earlier than that.
REQ-024 A start pulse while busy SHALL be ignored, and its cfg_* values SHALL not be latched.
REQ-025 Window counts: total reads = k*k*out_w*out_h*ch, and total mp_we pulses = out_w*out_h*ch.

Reset
REQ-026 On rst, FSM SHALL go to IDLE, and mem_re, mp_en, mp_we, busy, done SHALL be 0.
REQ-027 On rst, mem_ra, mp_wa, all counters and all latched configuration SHALL be 0.
REQ-028 rst asserted mid-operation SHALL abort immediately with no done pulse; the next start SHALL run normally.

Configuration
REQ-029 With MAXP_CTRL_PERF_EN defined, SHALL add output perf_cycles (32 bits): cleared on accepted start, incremented every busy cycle, held after done, saturating at all-ones.
REQ-030 Without MAXP_CTRL_PERF_EN, the port and counter SHALL not exist.

Structure
REQ-031 MEM_SIZE, DATA_SIZE and new constants (MAXP_CFG_W=12, MAXP_K_W=3, DRAIN_CYCLES=3) SHALL live in the shared param.v.
REQ-032 Counters and address adders SHALL be in sub-module maxp_addr_gen (step/last-flag interface); FSM, alignment delay and perf counter SHALL be in maxp_ctrl.

Verification
REQ-033 in 4x4, k=2, out 2x2, ch=1, src=0, dst=100, start -> mem_ra 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; mp_we on reads 4,8,12,16; mp_wa 100..103; done once.
REQ-034 Same config with maxp_unit attached, memory holds value=address+1 -> writes (100,6),(101,8),(102,14),(103,16).
REQ-035 in 3x3, k=3, ch=2, src=10 -> reads 10..18 then 19..27; 2 mp_we pulses, mp_wa dst, dst+1.
REQ-036 cfg_out_w=0, start -> done 2 cycles after start with zero mem_re; start pulsed during RUN -> ignored, read count unchanged.
REQ-037 rst asserted at read 5 of REQ-033 -> all outputs 0 next edge and no done; rerun -> identical sequence to REQ-033.
REQ-038 With MAXP_CTRL_PERF_EN, REQ-033 run -> perf_cycles = 1+16+3 = 20 after done.
